btn_debounce: RTL and testbench

BTN_DEBOUNCE -- requirements
Module: btn_debounce

---
 rtl/btn_debounce_pkg.sv | 17 +
 rtl/btn_debounce_sync_2ff.sv | 25 ++
 rtl/btn_debounce.sv | 153 +++++++++++++++
 tb/tb_btn_debounce.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/btn_debounce_pkg.sv
// Shared definitions for the button debouncer: FSM state encoding and
// the counter-width rule used by every counter in the block.
package btn_debounce_pkg;

  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_RISE = 2'd1,
    S_HIGH = 2'd2,
    S_FALL = 2'd3
  } deb_state_t;

  // Wide enough to hold the terminal value n itself, so no counter wraps.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/btn_debounce_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; reusable for any
// pin that is not related to clk.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/btn_debounce.sv
// Button debouncer: synchronizes a raw button, accepts a level change only
// after DEB_CYCLES equal samples, and adds long-press and auto-repeat outputs.
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int DEB_CYCLES  = 16,
  parameter int HOLD_CYCLES = 1000,
  parameter int REP_CYCLES  = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic level_out,
  output logic hold_out,
  output logic rep_pulse
);

  localparam int DEB_W  = cnt_width(DEB_CYCLES);
  localparam int HOLD_W = cnt_width(HOLD_CYCLES);
  localparam int REP_W  = cnt_width(REP_CYCLES);

  localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);
  localparam logic [REP_W-1:0]  REP_MAX  = REP_W'(REP_CYCLES);

  logic               w_btn_s;

  deb_state_t         r_state;
  deb_state_t         w_state_next;
  logic [DEB_W-1:0]   r_deb_cnt;
  logic [DEB_W-1:0]   w_deb_cnt_next;
  logic               r_level;
  logic               w_level_next;

  logic [HOLD_W-1:0]  r_hold_cnt;
  logic [HOLD_W-1:0]  w_hold_cnt_next;
  logic               r_hold;
  logic               w_hold_next;

  logic [REP_W-1:0]   r_rep_cnt;
  logic [REP_W-1:0]   w_rep_cnt_next;
  logic               r_rep;
  logic               w_rep_next;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (w_btn_s)
  );

  // The exit sample from a stable state counts as the first candidate sample.
  always_comb begin
    w_state_next   = r_state;
    w_deb_cnt_next = r_deb_cnt;
    case (r_state)
      S_LOW: begin
        if (w_btn_s) begin
          w_state_next   = S_RISE;
          w_deb_cnt_next = DEB_W'(1);
        end else begin
          w_deb_cnt_next = '0;
        end
      end
      S_RISE: begin
        if (!w_btn_s) begin
          w_state_next   = S_LOW;
          w_deb_cnt_next = '0;
        end else if (r_deb_cnt == DEB_LAST) begin
          w_state_next   = S_HIGH;
          w_deb_cnt_next = '0;
        end else begin
          w_deb_cnt_next = r_deb_cnt + DEB_W'(1);
        end
      end
      S_HIGH: begin
        if (!w_btn_s) begin
          w_state_next   = S_FALL;
          w_deb_cnt_next = DEB_W'(1);
        end else begin
          w_deb_cnt_next = '0;
        end
      end
      S_FALL: begin
        if (w_btn_s) begin
          w_state_next   = S_HIGH;
          w_deb_cnt_next = '0;
        end else if (r_deb_cnt == DEB_LAST) begin
          w_state_next   = S_LOW;
          w_deb_cnt_next = '0;
        end else begin
          w_deb_cnt_next = r_deb_cnt + DEB_W'(1);
        end
      end
      default: begin
        w_state_next   = S_LOW;
        w_deb_cnt_next = '0;
      end
    endcase
    w_level_next = (w_state_next == S_HIGH) || (w_state_next == S_FALL);
  end

  // Hold counts only cycles where the debounced level was already high, so
  // hold_out lands exactly HOLD_CYCLES edges after the level rise.
  always_comb begin
    w_hold_cnt_next = '0;
    if (r_level && w_level_next) begin
      if (r_hold_cnt == HOLD_MAX)
        w_hold_cnt_next = r_hold_cnt;
      else
        w_hold_cnt_next = r_hold_cnt + HOLD_W'(1);
    end
    w_hold_next = w_level_next && (w_hold_cnt_next == HOLD_MAX);
  end

  always_comb begin
    w_rep_cnt_next = '0;
    w_rep_next     = 1'b0;
    if (w_hold_next) begin
      if (!r_hold || (r_rep_cnt == REP_MAX)) begin
        w_rep_next     = 1'b1;
        w_rep_cnt_next = REP_W'(1);
      end else begin
        w_rep_cnt_next = r_rep_cnt + REP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_LOW;
      r_deb_cnt  <= '0;
      r_level    <= 1'b0;
      r_hold_cnt <= '0;
      r_hold     <= 1'b0;
      r_rep_cnt  <= '0;
      r_rep      <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_deb_cnt  <= w_deb_cnt_next;
      r_level    <= w_level_next;
      r_hold_cnt <= w_hold_cnt_next;
      r_hold     <= w_hold_next;
      r_rep_cnt  <= w_rep_cnt_next;
      r_rep      <= w_rep_next;
    end
  end

  assign level_out = r_level;
  assign hold_out  = r_hold;
  assign rep_pulse = r_rep;

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce: directed scenarios with fixed edge
// counts plus a randomized run against a behavioural run-length model.
module tb_btn_debounce;
  import btn_debounce_pkg::*;

  localparam int DEB  = 4;
  localparam int HOLD = 10;
  localparam int REP  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_in = 1'b0;
  logic level_out, hold_out, rep_pulse;

  int checks = 0;
  int errors = 0;

  // Reference model: samples seen two edges late, run length of samples
  // disagreeing with the accepted level, edges since the level rose.
  bit m_d1, m_d2, m_lvl;
  int m_run, m_on;

  btn_debounce #(
    .DEB_CYCLES (DEB),
    .HOLD_CYCLES(HOLD),
    .REP_CYCLES (REP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_in   (btn_in),
    .level_out(level_out),
    .hold_out (hold_out),
    .rep_pulse(rep_pulse)
  );

  always #5 clk = ~clk;

  function bit exp_hold();
    return m_lvl && (m_on >= HOLD);
  endfunction

  function bit exp_rep();
    return exp_hold() && (((m_on - HOLD) % REP) == 0);
  endfunction

  task model_reset();
    m_d1 = 1'b0; m_d2 = 1'b0; m_lvl = 1'b0; m_run = 0; m_on = 0;
  endtask

  task tick();
    bit samp, prev;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      samp = m_d2;
      m_d2 = m_d1;
      m_d1 = btn_in;
      prev = m_lvl;
      if (samp != m_lvl) begin
        m_run++;
        if (m_run == DEB) begin
          m_lvl = ~m_lvl;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      if (prev && m_lvl) m_on++;
      else m_on = 0;
    end
    #1;
  endtask

  task idle(input int n);
    btn_in = 1'b0;
    repeat (n) tick();
  endtask

  task test_reset();
    rst = 1'b1; btn_in = 1'b0; model_reset();
    repeat (3) tick();
    checks++; if (level_out !== 1'b0) begin errors++; $display("FAIL reset_level: got %b expected 0", level_out); end
    checks++; if (hold_out !== 1'b0) begin errors++; $display("FAIL reset_hold: got %b expected 0", hold_out); end
    checks++; if (rep_pulse !== 1'b0) begin errors++; $display("FAIL reset_rep: got %b expected 0", rep_pulse); end
    checks++; if (dut.r_state !== S_LOW) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dut.r_state, S_LOW); end
    rst = 1'b0;
    repeat (4) tick();
    checks++; if (level_out !== 1'b0) begin errors++; $display("FAIL idle_level: got %b expected 0", level_out); end
    $display("test_reset done");
  endtask

  task test_clean_press();
    bit e;
    btn_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      e = (i == 5);
      checks++; if (level_out !== e) begin errors++; $display("FAIL press_edge%0d: got %b expected %b", i, level_out, e); end
    end
    btn_in = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      e = (i != 5);
      checks++; if (level_out !== e) begin errors++; $display("FAIL release_edge%0d: got %b expected %b", i, level_out, e); end
      checks++; if (hold_out !== 1'b0) begin errors++; $display("FAIL release_hold%0d: got %b expected 0", i, hold_out); end
    end
    idle(10);
    $display("test_clean_press done");
  endtask

  task test_bounce();
    bit pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      btn_in = pat[i];
      tick();
      checks++; if (level_out !== 1'b0) begin errors++; $display("FAIL bounce_level%0d: got %b expected 0", i, level_out); end
    end
    btn_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (level_out !== 1'b0) begin errors++; $display("FAIL bounce_tail%0d: got %b expected 0", i, level_out); end
    end
    checks++; if (dut.r_state !== S_LOW) begin errors++; $display("FAIL bounce_state: got %0d expected %0d", dut.r_state, S_LOW); end
    $display("test_bounce done");
  endtask

  task test_release_glitch();
    bit eh;
    btn_in = 1'b1;
    repeat (6) tick();
    checks++; if (level_out !== 1'b1) begin errors++; $display("FAIL glitch_rise: got %b expected 1", level_out); end
    for (int k = 1; k <= 12; k++) begin
      btn_in = (k == 3 || k == 4) ? 1'b0 : 1'b1;
      tick();
      eh = (k >= HOLD);
      checks++; if (level_out !== 1'b1) begin errors++; $display("FAIL glitch_level%0d: got %b expected 1", k, level_out); end
      checks++; if (hold_out !== eh) begin errors++; $display("FAIL glitch_hold%0d: got %b expected %b", k, hold_out, eh); end
    end
    idle(12);
    $display("test_release_glitch done");
  endtask

  task test_long_press();
    bit el, eh, er;
    btn_in = 1'b1;
    repeat (6) tick();
    checks++; if (level_out !== 1'b1) begin errors++; $display("FAIL long_rise: got %b expected 1", level_out); end
    for (int k = 1; k <= 26; k++) begin
      if (k == 21) btn_in = 1'b0;
      tick();
      el = (k < 26);
      eh = el && (k >= HOLD);
      er = eh && (((k - HOLD) % REP) == 0);
      checks++; if (level_out !== el) begin errors++; $display("FAIL long_level%0d: got %b expected %b", k, level_out, el); end
      checks++; if (hold_out !== eh) begin errors++; $display("FAIL long_hold%0d: got %b expected %b", k, hold_out, eh); end
      checks++; if (rep_pulse !== er) begin errors++; $display("FAIL long_rep%0d: got %b expected %b", k, rep_pulse, er); end
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (rep_pulse !== 1'b0) begin errors++; $display("FAIL long_rep_stop%0d: got %b expected 0", i, rep_pulse); end
    end
    idle(8);
    $display("test_long_press done");
  endtask

  task test_reset_mid();
    bit e;
    btn_in = 1'b1;
    repeat (6 + 12) tick();
    checks++; if (hold_out !== 1'b1) begin errors++; $display("FAIL mid_pre_hold: got %b expected 1", hold_out); end
    rst = 1'b1;
    model_reset();
    #1;
    checks++; if (level_out !== 1'b0) begin errors++; $display("FAIL mid_rst_level: got %b expected 0", level_out); end
    checks++; if (hold_out !== 1'b0) begin errors++; $display("FAIL mid_rst_hold: got %b expected 0", hold_out); end
    checks++; if (rep_pulse !== 1'b0) begin errors++; $display("FAIL mid_rst_rep: got %b expected 0", rep_pulse); end
    repeat (2) tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      e = (i == 5);
      checks++; if (level_out !== e) begin errors++; $display("FAIL mid_relock%0d: got %b expected %b", i, level_out, e); end
    end
    for (int k = 1; k <= HOLD; k++) begin
      tick();
      e = (k == HOLD);
      checks++; if (hold_out !== e) begin errors++; $display("FAIL mid_hold%0d: got %b expected %b", k, hold_out, e); end
    end
    idle(20);
    $display("test_reset_mid done");
  endtask

  task test_random();
    bit b;
    int len;
    for (int seg = 0; seg < 300; seg++) begin
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        model_reset();
        tick();
        rst = 1'b0;
      end
      b = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(10, 30)) : int'($urandom_range(1, 6));
      for (int i = 0; i < len; i++) begin
        btn_in = b;
        tick();
        checks++; if (level_out !== m_lvl) begin errors++; $display("FAIL rand_level seg%0d: got %b expected %b", seg, level_out, m_lvl); end
        checks++; if (hold_out !== exp_hold()) begin errors++; $display("FAIL rand_hold seg%0d: got %b expected %b", seg, hold_out, exp_hold()); end
        checks++; if (rep_pulse !== exp_rep()) begin errors++; $display("FAIL rand_rep seg%0d: got %b expected %b", seg, rep_pulse, exp_rep()); end
      end
    end
    $display("test_random done");
  endtask

  initial begin
    model_reset();
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_glitch();
    test_long_press();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
